// File: rtl/sva_stim_pkg.sv
// sva_stim_pkg: shared state/pattern types and constants for the SVA stimulus generator.
package sva_stim_pkg;

  typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE} stim_state_t;

  typedef enum logic [1:0] {P_ZERO, P_ONE, P_ALT, P_LFSR} pattern_mode_t;

  // Taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  localparam int unsigned DRAIN_PERIODS = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sva_stim_lfsr.sv
// sva_stim_lfsr: 16-bit Fibonacci LFSR; fb is the bit shifted in on the next step.
module sva_stim_lfsr
  import sva_stim_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] seed,
  input  logic        load,
  input  logic        step,
  output logic        fb
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign fb = ^(lfsr_q & LFSR_TAPS);

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = {lfsr_q[14:0], fb};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/sva_stim_gen.sv
// sva_stim_gen: derives gclk, grst and property input a for an SVA checker from sys_clk.
// Define SVA_STIM_RESULT_CNT_EN to add the succ/fail/lazy_succ result counters.
module sva_stim_gen
  import sva_stim_pkg::*;
#(
  parameter int unsigned GCLK_HALF_PERIOD = 4,
  parameter int unsigned GRST_CYCLES      = 2,
  parameter int unsigned NUM_CYCLES       = 64,
  parameter logic [15:0] LFSR_SEED        = DEFAULT_SEED
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [1:0]  pattern_mode,
  output logic        busy,
  output logic        done,
  output logic        gclk,
  output logic        grst,
  output logic        a,
  output logic [15:0] cycle_cnt
`ifdef SVA_STIM_RESULT_CNT_EN
  ,
  input  logic        succ,
  input  logic        fail,
  input  logic        lazy_succ,
  output logic [15:0] succ_cnt,
  output logic [15:0] fail_cnt,
  output logic [15:0] lazy_cnt
`endif
);

  localparam int unsigned     HP_W        = $clog2(GCLK_HALF_PERIOD);
  localparam logic [HP_W-1:0] HP_LAST     = HP_W'(GCLK_HALF_PERIOD - 1);
  localparam logic [15:0]     GRST_TARGET = 16'(GRST_CYCLES);
  localparam logic [15:0]     RUN_TARGET  = 16'(NUM_CYCLES);
  localparam logic [15:0]     DRAIN_LAST  = 16'(DRAIN_PERIODS - 1);

  stim_state_t   state_q, state_d;
  pattern_mode_t mode_q, mode_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic        gclk_q, gclk_d;
  logic        grst_q, grst_d;
  logic        a_q, a_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;

  logic lfsr_load;
  logic lfsr_step;
  logic lfsr_fb;
  logic hp_wrap;
  logic gclk_rise;
  logic gclk_fall;
  logic start_accept;
  logic pattern_a;

  assign hp_wrap      = (hp_q == HP_LAST);
  assign gclk_rise    = hp_wrap && !gclk_q;
  assign gclk_fall    = hp_wrap && gclk_q;
  assign start_accept = (state_q == IDLE) && start;

  sva_stim_lfsr u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .seed    (LFSR_SEED),
    .load    (lfsr_load),
    .step    (lfsr_step),
    .fb      (lfsr_fb)
  );

  // Alternating mode relies on a being 0 on entry to RUN, so its first value is 1.
  always_comb begin
    pattern_a = 1'b0;
    case (mode_q)
      P_ZERO:  pattern_a = 1'b0;
      P_ONE:   pattern_a = 1'b1;
      P_ALT:   pattern_a = ~a_q;
      P_LFSR:  pattern_a = lfsr_fb;
      default: pattern_a = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    hp_d        = hp_q;
    gclk_d      = gclk_q;
    grst_d      = grst_q;
    a_d         = a_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cycle_cnt_d = cycle_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    if (state_q inside {RESET, RUN, DRAIN}) begin
      hp_d   = hp_wrap ? '0 : hp_q + HP_W'(1);
      gclk_d = gclk_q ^ hp_wrap;
    end

    case (state_q)
      IDLE: begin
        hp_d   = '0;
        gclk_d = 1'b0;
        grst_d = 1'b1;
        a_d    = 1'b0;
        busy_d = 1'b0;
        if (start_accept) begin
          state_d     = RESET;
          mode_d      = pattern_mode_t'(pattern_mode);
          lfsr_load   = 1'b1;
          cycle_cnt_d = '0;
          edge_cnt_d  = '0;
          busy_d      = 1'b1;
        end
      end
      RESET: begin
        if (gclk_rise) begin
          edge_cnt_d = edge_cnt_q + 16'd1;
        end
        if (gclk_fall && edge_cnt_q == GRST_TARGET) begin
          state_d   = RUN;
          grst_d    = 1'b0;
          a_d       = pattern_a;
          lfsr_step = (mode_q == P_LFSR);
        end
      end
      RUN: begin
        if (gclk_rise) begin
          cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
        if (gclk_fall) begin
          if (cycle_cnt_q == RUN_TARGET) begin
            state_d    = DRAIN;
            a_d        = 1'b0;
            edge_cnt_d = '0;
          end else begin
            a_d       = pattern_a;
            lfsr_step = (mode_q == P_LFSR);
          end
        end
      end
      DRAIN: begin
        if (gclk_fall) begin
          if (edge_cnt_q == DRAIN_LAST) begin
            state_d = DONE;
            hp_d    = '0;
            gclk_d  = 1'b0;
            grst_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + 16'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        hp_d    = '0;
        gclk_d  = 1'b0;
        grst_d  = 1'b1;
        a_d     = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      mode_q      <= P_ZERO;
      hp_q        <= '0;
      gclk_q      <= 1'b0;
      grst_q      <= 1'b1;
      a_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
      edge_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      hp_q        <= hp_d;
      gclk_q      <= gclk_d;
      grst_q      <= grst_d;
      a_q         <= a_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cycle_cnt_q <= cycle_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gclk      = gclk_q;
  assign grst      = grst_q;
  assign a         = a_q;
  assign cycle_cnt = cycle_cnt_q;

`ifdef SVA_STIM_RESULT_CNT_EN
  logic [15:0] succ_cnt_q, succ_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic [15:0] lazy_cnt_q, lazy_cnt_d;

  // Counts are taken over the registered busy window, i.e. exactly the active run.
  always_comb begin
    succ_cnt_d = succ_cnt_q;
    fail_cnt_d = fail_cnt_q;
    lazy_cnt_d = lazy_cnt_q;
    if (start_accept) begin
      succ_cnt_d = '0;
      fail_cnt_d = '0;
      lazy_cnt_d = '0;
    end else if (busy_q) begin
      if (succ)      succ_cnt_d = sat_inc16(succ_cnt_q);
      if (fail)      fail_cnt_d = sat_inc16(fail_cnt_q);
      if (lazy_succ) lazy_cnt_d = sat_inc16(lazy_cnt_q);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      succ_cnt_q <= '0;
      fail_cnt_q <= '0;
      lazy_cnt_q <= '0;
    end else begin
      succ_cnt_q <= succ_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      lazy_cnt_q <= lazy_cnt_d;
    end
  end

  assign succ_cnt = succ_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign lazy_cnt = lazy_cnt_q;
`endif

endmodule
